// File: rtl/store_write_ctrl.sv
// store_write_ctrl: issues one aligned, byte-enabled 32-bit store to data memory,
// waits for i_mem_ack (bounded by TIMEOUT_CYC) and reports o_done or o_err.
// Optional build macro: MISALIGN_TRAP_EN -- when defined, misaligned half/word
// stores are rejected to ERR without a write; when undefined, the offending low
// address bits are ignored and the store proceeds.
//
// Handshake: a request is accepted only when i_req is high at a rising edge in
// IDLE (o_busy low); i_mem_ack is a level sampled only while o_mem_we is high, and
// a single high sample completes the store. Requests and acks elsewhere are dropped.
module store_write_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [1:0]        i_size,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic              i_mem_ack,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  // Last counter value allowed in WRITE before giving up (unused when TIMEOUT_CYC=0).
  localparam bit               TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic              req_legal;
  logic [3:0]        req_be;
  logic [31:0]       req_data;

  // Decode lane enables, replicated data and legality of the incoming request.
  always_comb begin
    req_legal = 1'b1;
    req_be    = 4'b0000;
    req_data  = 32'h0;
    case (i_size)
      2'b00: begin
        req_be   = 4'b0001 << i_addr[1:0];
        req_data = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        req_be   = i_addr[1] ? 4'b1100 : 4'b0011;
        req_data = {2{i_wdata[15:0]}};
`ifdef MISALIGN_TRAP_EN
        if (i_addr[0]) req_legal = 1'b0;
`endif
      end
      2'b10: begin
        req_be   = 4'b1111;
        req_data = i_wdata;
`ifdef MISALIGN_TRAP_EN
        if (i_addr[1:0] != 2'b00) req_legal = 1'b0;
`endif
      end
      default: req_legal = 1'b0;
    endcase
  end

  // Next-state, counter and latched-store logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
          wdata_d = req_data;
          be_d    = req_be;
          cnt_d   = '0;
          state_d = req_legal ? S_WRITE : S_ERR;
        end
      end
      S_WRITE: begin
        // Ack has priority over a timeout landing in the same cycle.
        if (i_mem_ack) begin
          state_d = S_DONE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d = S_ERR;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and registered Moore outputs decoded from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_mem_we <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      o_busy   <= (state_d != S_IDLE);
      o_done   <= (state_d == S_DONE);
      o_err    <= (state_d == S_ERR);
      o_mem_we <= (state_d == S_WRITE);
    end
  end

  // Latched store address/data/enables, held stable for the whole WRITE phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_be    = be_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_store_write_ctrl.sv
// tb_store_write_ctrl: directed bench for store_write_ctrl. Instance A uses the
// default timeout (16), instance B uses TIMEOUT_CYC=4 for the timeout scenario.
// Expected memory writes and outcomes are queued when a store is driven and
// compared by a monitor when the DUT produces them.
module tb_store_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        ack_a = 1'b0, ack_b = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  size = '0;

  logic        busy_a, done_a, err_a, we_a;
  logic [31:0] maddr_a, mwdata_a;
  logic [3:0]  be_a;
  logic [1:0]  st_a;
  logic        busy_b, done_b, err_b, we_b;
  logic [31:0] maddr_b, mwdata_b;
  logic [3:0]  be_b;
  logic [1:0]  st_b;

  int checks = 0;
  int errors = 0;

  logic [67:0] exp_q[$];   // {mem_addr, be, wdata} expected per write on DUT A
  logic        res_q[$];   // 1 = done expected, 0 = err expected (DUT A)
  logic        we_a_prev = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  store_write_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(16), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_a), .i_addr(addr), .i_wdata(wdata),
    .i_size(size), .o_busy(busy_a), .o_done(done_a), .o_err(err_a), .o_mem_we(we_a),
    .o_mem_addr(maddr_a), .o_mem_wdata(mwdata_a), .o_mem_be(be_a), .i_mem_ack(ack_a),
    .o_dbg_state(st_a)
  );

  store_write_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(4), .CNT_W(8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_addr(addr), .i_wdata(wdata),
    .i_size(size), .o_busy(busy_b), .o_done(done_b), .o_err(err_b), .o_mem_we(we_b),
    .o_mem_addr(maddr_b), .o_mem_wdata(mwdata_b), .o_mem_be(be_b), .i_mem_ack(ack_b),
    .o_dbg_state(st_b)
  );

  // ---------------- checker / model ----------------
  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [67:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                              input logic [1:0] sz);
    logic [3:0]  be;
    logic [31:0] wd;
    be = 4'b0000;
    wd = 32'h0;
    case (sz)
      2'b00: begin
        case (a[1:0])
          2'd0: be = 4'b0001;
          2'd1: be = 4'b0010;
          2'd2: be = 4'b0100;
          default: be = 4'b1000;
        endcase
        wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
      end
      2'b01: begin
        be = a[1] ? 4'b1100 : 4'b0011;
        wd = {d[15:0], d[15:0]};
      end
      default: begin
        be = 4'b1111;
        wd = d;
      end
    endcase
    return {a[31:2], 2'b00, be, wd};
  endfunction

  // ---------------- scoreboard monitor (DUT A) ----------------
  always @(negedge clk) begin
    if (rst_n && we_a && !we_a_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {maddr_a, be_a, mwdata_a}, 68'h0);
      end else begin
        check("write_lanes", {maddr_a, be_a, mwdata_a}, exp_q.pop_front());
      end
    end
    if (rst_n && (done_a || err_a)) begin
      if (res_q.size() == 0) begin
        check("unexpected_outcome", {done_a, err_a}, 2'b00);
      end else begin
        check("outcome_done", done_a, res_q.pop_front());
      end
    end
    we_a_prev = we_a;
  end

  // ---------------- driver ----------------
  // ack_after: number of WRITE cycles with ack low before it is raised (<0: never).
  // lat: count of rising edges from request capture to the done/err pulse.
  task automatic store(input bit sel, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input int ack_after, input bit exp_wr,
                       input bit exp_ok, input bit pulse_req,
                       output int we_n, output int busy_n, output int lat,
                       output bit got_ok);
    logic c_we, c_busy, c_done, c_err;
    if (!sel && exp_wr) exp_q.push_back(model_write(a, d, sz));
    if (!sel) res_q.push_back(exp_ok);
    we_n = 0; busy_n = 0; lat = 0; got_ok = 1'b0;
    @(negedge clk);
    addr = a; wdata = d; size = sz;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0;
      c_we   = sel ? we_b   : we_a;
      c_busy = sel ? busy_b : busy_a;
      c_done = sel ? done_b : done_a;
      c_err  = sel ? err_b  : err_a;
      if (c_we) begin
        we_n++;
        if (ack_after >= 0 && we_n > ack_after) begin
          if (sel) ack_b = 1'b1; else ack_a = 1'b1;
        end
        // A request raised mid-WRITE must be ignored.
        if (pulse_req && we_n == 1) begin
          if (sel) req_b = 1'b1; else req_a = 1'b1;
        end
      end
      if (c_busy) busy_n++;
      if (c_done || c_err) begin
        lat = i;
        got_ok = c_done;
        // A request raised during DONE must be ignored too.
        if (pulse_req) begin
          if (sel) req_b = 1'b1; else req_a = 1'b1;
        end
        break;
      end
    end
    ack_a = 1'b0; ack_b = 1'b0;
    check("store_finished", lat != 0, 1'b1);
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    check("pulse_single", sel ? {done_b, err_b} : {done_a, err_a}, 2'b00);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  we_n, busy_n, lat;
    bit  ok;
    logic [31:0] ra, rd;
    logic [1:0]  rs;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_a", {busy_a, done_a, err_a, we_a, be_a, st_a, maddr_a, mwdata_a}, 96'h0);
    check("rst_b", {busy_b, done_b, err_b, we_b, be_b, st_b, maddr_b, mwdata_b}, 96'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: byte store, ack in first WRITE cycle. o_done rises on the 2nd rising
    // edge after the request is driven (capture edge, ack edge), i.e. it is seen
    // by a consumer on the 3rd edge.
    store(1'b0, 32'h103, 32'hAB, 2'b00, 0, 1'b1, 1'b1, 1'b0, we_n, busy_n, lat, ok);
    check("t1_lat", lat, 2);
    check("t1_we", we_n, 1);
    check("t1_ok", ok, 1'b1);

    // 2: word store, ack low 5 WRITE cycles
    store(1'b0, 32'h200, 32'hDEADBEEF, 2'b10, 5, 1'b1, 1'b1, 1'b0, we_n, busy_n, lat, ok);
    check("t2_we", we_n, 6);
    check("t2_busy", busy_n, 7);
    check("t2_ok", ok, 1'b1);

    // 3: misaligned half store
`ifdef MISALIGN_TRAP_EN
    store(1'b0, 32'h201, 32'h1234CAFE, 2'b01, 0, 1'b0, 1'b0, 1'b0, we_n, busy_n, lat, ok);
    check("t3_we", we_n, 0);
    check("t3_ok", ok, 1'b0);
    store(1'b0, 32'h203, 32'h01020304, 2'b10, 0, 1'b0, 1'b0, 1'b0, we_n, busy_n, lat, ok);
    check("t3w_we", we_n, 0);
`else
    store(1'b0, 32'h201, 32'h1234CAFE, 2'b01, 0, 1'b1, 1'b1, 1'b0, we_n, busy_n, lat, ok);
    check("t3_we", we_n, 1);
    check("t3_ok", ok, 1'b1);
    store(1'b0, 32'h203, 32'h01020304, 2'b10, 1, 1'b1, 1'b1, 1'b0, we_n, busy_n, lat, ok);
    check("t3w_ok", ok, 1'b1);
`endif
    // Upper half lane and a middle byte lane
    store(1'b0, 32'h102, 32'h5566BEEF, 2'b01, 0, 1'b1, 1'b1, 1'b0, we_n, busy_n, lat, ok);
    store(1'b0, 32'h101, 32'h0000007E, 2'b00, 2, 1'b1, 1'b1, 1'b0, we_n, busy_n, lat, ok);
    check("lane_ok", ok, 1'b1);

    // Random aligned stores with random ack delay
    for (int k = 0; k < 6; k++) begin
      rs = 2'($urandom_range(0, 2));
      ra = $urandom & 32'hFFFF_FFFC;
      if (rs == 2'b00) ra[1:0] = 2'($urandom_range(0, 3));
      if (rs == 2'b01) ra[1] = 1'($urandom_range(0, 1));
      rd = $urandom;
      store(1'b0, ra, rd, rs, int'($urandom_range(0, 4)), 1'b1, 1'b1, 1'b0,
            we_n, busy_n, lat, ok);
      check("rand_ok", ok, 1'b1);
    end

    // 4: timeout on DUT B (TIMEOUT_CYC=4), ack never
    store(1'b1, 32'h300, 32'h55AA1234, 2'b10, -1, 1'b0, 1'b0, 1'b0, we_n, busy_n, lat, ok);
    check("t4_we", we_n, 4);
    check("t4_ok", ok, 1'b0);
    check("t4_idle", {busy_b, we_b, st_b}, 4'h0);
    check("t4_latched", {maddr_b, be_b, mwdata_b}, {32'h300, 4'b1111, 32'h55AA1234});
    // Reserved size on DUT A: error one edge after request, no write
    store(1'b0, 32'h400, 32'h11111111, 2'b11, 0, 1'b0, 1'b0, 1'b0, we_n, busy_n, lat, ok);
    check("t4s_we", we_n, 0);
    check("t4s_lat", lat, 1);
    check("t4s_ok", ok, 1'b0);

    // 5: asynchronous reset mid-WRITE
    exp_q.push_back(model_write(32'h500, 32'hCAFEF00D, 2'b10));
    @(negedge clk);
    addr = 32'h500; wdata = 32'hCAFEF00D; size = 2'b10; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    check("t5_in_write", {st_a, we_a, busy_a}, {2'd1, 1'b1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check("t5_async", {we_a, busy_a, st_a}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // New store completes; requests pulsed in WRITE and DONE are dropped
    store(1'b0, 32'h604, 32'h87654321, 2'b10, 2, 1'b1, 1'b1, 1'b1, we_n, busy_n, lat, ok);
    check("t5_we", we_n, 3);
    check("t5_ok", ok, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_dropped", {busy_a, we_a}, 2'b00);
    end

    check("exp_q_empty", exp_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
